// File: rtl/led_timer_bank.sv
// Multi-channel LED timer bank: a shared prescaler tick drives per-channel toggle/one-shot/strobe counters.
// Latency: sw reaches the channel logic after 2 clk; led/wrap are registered one clk after the deciding cycle.
// No flow control: every input is sampled every cycle, and outputs are free-running and cannot be stalled.
module led_timer_bank #(
    parameter int CHANNELS = 4,
    parameter int CLK_HZ   = 10000000,
    parameter int TICK_HZ  = 1000,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       sw,
    input  logic [2*CHANNELS-1:0]     mode,
    input  logic [CNT_W*CHANNELS-1:0] period,
    output logic [CHANNELS-1:0]       led,
    output logic [CHANNELS-1:0]       wrap,
    output logic                      tick
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_TOGGLE  = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    // Reject unusable parameter sets at elaboration rather than building a broken prescaler.
    if (DIV < 2) begin : g_bad_div
        $error("led_timer_bank: CLK_HZ/TICK_HZ must be at least 2");
    end
    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
        $error("led_timer_bank: CHANNELS must be in 1..16");
    end

    logic [PW-1:0]       presc_q;
    logic [PW-1:0]       presc_d;
    logic [CHANNELS-1:0] sw_meta_q;
    logic [CHANNELS-1:0] sw_s_q;
    logic [CHANNELS-1:0] sw_dly_q;
    logic [CHANNELS-1:0] sw_rise;

    // The tick is decoded straight from the prescaler so every channel sees the same single-cycle strobe.
    assign tick    = (presc_q == PRESC_MAX);
    assign sw_rise = sw_s_q & ~sw_dly_q;

    // Prescaler next state: count up and wrap on the tick cycle.
    always_comb begin
        presc_d = presc_q + PW'(1);
        if (tick) begin
            presc_d = '0;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // Two-flop synchroniser for the asynchronous switches, plus one extra stage for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta_q <= '0;
            sw_s_q    <= '0;
            sw_dly_q  <= '0;
        end else begin
            sw_meta_q <= sw;
            sw_s_q    <= sw_meta_q;
            sw_dly_q  <= sw_s_q;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [CNT_W-1:0] per_w;
        logic [1:0]       md_w;
        logic             done_w;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic [1:0]       pmode_q;
        logic             led_q;
        logic             led_d;
        logic             busy_q;
        logic             busy_d;
        logic             wrap_q;
        logic             wrap_d;

        assign per_w  = period[CNT_W*i +: CNT_W];
        assign md_w   = mode[2*i +: 2];
        // A >= compare lets a shrunken period finish on the next tick and keeps the counter from overflowing.
        assign done_w = (cnt_q >= per_w - CNT_W'(1));

        // Channel next state: mode change and idle conditions clear first, then the active mode's rule applies.
        always_comb begin
            cnt_d  = cnt_q;
            led_d  = led_q;
            busy_d = busy_q;
            wrap_d = 1'b0;
            if (md_w != pmode_q || per_w == '0 || md_w == MODE_OFF) begin
                cnt_d  = '0;
                led_d  = 1'b0;
                busy_d = 1'b0;
            end else begin
                case (md_w)
                    MODE_TOGGLE: begin
                        // Switch low pauses the channel with count and led frozen.
                        if (sw_s_q[i] && tick) begin
                            if (done_w) begin
                                cnt_d  = '0;
                                led_d  = ~led_q;
                                wrap_d = 1'b1;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    MODE_ONESHOT: begin
                        // A retrigger beats a coincident completion: the pulse is simply extended.
                        if (sw_rise[i]) begin
                            led_d  = 1'b1;
                            busy_d = 1'b1;
                            cnt_d  = '0;
                        end else if (tick && busy_q) begin
                            if (done_w) begin
                                led_d  = 1'b0;
                                busy_d = 1'b0;
                                wrap_d = 1'b1;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        // Strobe: led is high for the one tick interval following each completion.
                        if (!sw_s_q[i]) begin
                            led_d = 1'b0;
                        end else if (tick) begin
                            if (done_w) begin
                                cnt_d  = '0;
                                led_d  = 1'b1;
                                wrap_d = 1'b1;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                                led_d = 1'b0;
                            end
                        end
                    end
                endcase
            end
        end

        // Channel state registers; prev_mode follows mode every cycle.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q   <= '0;
                pmode_q <= MODE_OFF;
                led_q   <= 1'b0;
                busy_q  <= 1'b0;
                wrap_q  <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                pmode_q <= md_w;
                led_q   <= led_d;
                busy_q  <= busy_d;
                wrap_q  <= wrap_d;
            end
        end

        assign led[i]  = led_q;
        assign wrap[i] = wrap_q;
    end

endmodule

// File: tb/tb_led_timer_bank.sv
// Bench for led_timer_bank: directed scenarios plus random switching, checked against a behavioural model.
// Latency: the model predicts register state one clk edge at a time and is compared 1 time unit after each edge.
// No flow control: the stimulus drives inputs freely every cycle.
module tb_led_timer_bank;

    localparam int CH      = 4;
    localparam int CW      = 8;
    localparam int CLK_HZ  = 100;
    localparam int TICK_HZ = 10;
    localparam int DIV     = CLK_HZ / TICK_HZ;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [CH-1:0]    sw = '0;
    logic [2*CH-1:0]  mode = '0;
    logic [CW*CH-1:0] period = '0;
    logic [CH-1:0]    led;
    logic [CH-1:0]    wrap;
    logic             tick;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: clock-edge count since reset, a switch delay line, and per-channel integers.
    int            edges;
    bit [CH-1:0]   sw_hist[$];
    int            m_cnt[CH];
    bit            m_led[CH];
    bit            m_busy[CH];
    bit            m_wrap[CH];
    bit [1:0]      m_pmode[CH];

    always #5 clk = ~clk;

    led_timer_bank #(
        .CHANNELS(CH),
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .CNT_W   (CW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .sw    (sw),
        .mode  (mode),
        .period(period),
        .led   (led),
        .wrap  (wrap),
        .tick  (tick)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        edges = 0;
        sw_hist = {};
        for (int i = 0; i < 3; i++) sw_hist.push_back('0);
        for (int i = 0; i < CH; i++) begin
            m_cnt[i]   = 0;
            m_led[i]   = 1'b0;
            m_busy[i]  = 1'b0;
            m_wrap[i]  = 1'b0;
            m_pmode[i] = 2'b00;
        end
    endtask

    // Apply one clock edge worth of the channel rules, using the inputs present before the edge.
    task automatic model_edge();
        bit          tk;
        bit [CH-1:0] s_now;
        bit [CH-1:0] s_old;
        int          p;
        bit [1:0]    md;
        bit          on;
        bit          rise;
        bit          done;
        tk    = ((edges % DIV) == DIV - 1);
        s_now = sw_hist[1];
        s_old = sw_hist[2];
        for (int i = 0; i < CH; i++) begin
            p    = int'(period[CW*i +: CW]);
            md   = mode[2*i +: 2];
            on   = s_now[i];
            rise = s_now[i] && !s_old[i];
            done = (m_cnt[i] >= p - 1);
            m_wrap[i] = 1'b0;
            if (md != m_pmode[i] || p == 0 || md == 2'b00) begin
                m_cnt[i] = 0; m_led[i] = 1'b0; m_busy[i] = 1'b0;
            end else if (md == 2'b01) begin
                if (on && tk) begin
                    if (done) begin m_cnt[i] = 0; m_led[i] = !m_led[i]; m_wrap[i] = 1'b1; end
                    else m_cnt[i] = m_cnt[i] + 1;
                end
            end else if (md == 2'b10) begin
                if (rise) begin
                    m_led[i] = 1'b1; m_busy[i] = 1'b1; m_cnt[i] = 0;
                end else if (tk && m_busy[i]) begin
                    if (done) begin m_led[i] = 1'b0; m_busy[i] = 1'b0; m_wrap[i] = 1'b1; end
                    else m_cnt[i] = m_cnt[i] + 1;
                end
            end else begin
                if (!on) m_led[i] = 1'b0;
                else if (tk) begin
                    if (done) begin m_cnt[i] = 0; m_led[i] = 1'b1; m_wrap[i] = 1'b1; end
                    else begin m_led[i] = 1'b0; m_cnt[i] = m_cnt[i] + 1; end
                end
            end
            m_pmode[i] = md;
        end
        sw_hist.push_front(sw);
        void'(sw_hist.pop_back());
        edges++;
    endtask

    task automatic compare();
        logic [CH-1:0] el;
        logic [CH-1:0] ew;
        for (int i = 0; i < CH; i++) begin
            el[i] = m_led[i];
            ew[i] = m_wrap[i];
        end
        check("led", 32'(led), 32'(el));
        check("wrap", 32'(wrap), 32'(ew));
        check("tick", 32'(tick), 32'((edges % DIV) == DIV - 1));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            compare();
        end
    endtask

    task automatic set_mode(input int ch, input logic [1:0] m);
        mode[2*ch +: 2] = m;
    endtask

    task automatic set_per(input int ch, input int p);
        period[CW*ch +: CW] = CW'(p);
    endtask

    // Step until channel ch's model count reaches target; an expired bound is reported as a failure.
    task automatic wait_cnt(input int ch, input int target, input string tag);
        int k;
        k = 0;
        while (m_cnt[ch] != target && k < 200) begin
            step(1);
            k++;
        end
        check(tag, 32'(k < 200), 32'd1);
    endtask

    // Assert reset between edges: outputs must clear without waiting for a clock.
    task automatic async_reset();
        rst = 1'b1;
        #1;
        check("arst_led", 32'(led), 32'd0);
        check("arst_wrap", 32'(wrap), 32'd0);
        check("arst_tick", 32'(tick), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int wraps;
        model_reset();
        #12;
        check("rst_led", 32'(led), 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Idle: tick cadence from release.
        for (int i = 1; i <= 30; i++) begin
            step(1);
            check("tick_sched", 32'(tick), 32'((i % DIV) == DIV - 1));
        end

        // ch0 toggle, period 3.
        set_per(0, 3); set_mode(0, 2'b01); sw[0] = 1'b1;
        step(150);

        // Pause after tick 1 of 3, then resume.
        wait_cnt(0, 1, "wait_pause");
        sw[0] = 1'b0;
        step(50);
        sw[0] = 1'b1;
        step(80);

        // Reset in the middle of counting.
        wait_cnt(0, 1, "wait_arst");
        step(3);
        async_reset();
        step(20);

        // ch1 one-shot, period 5, with a retrigger.
        set_per(1, 5); set_mode(1, 2'b10);
        step(5);
        sw[1] = 1'b1;
        step(2);
        check("oneshot_early", 32'(led[1]), 32'd0);
        step(1);
        check("oneshot_on", 32'(led[1]), 32'd1);
        step(70);
        sw[1] = 1'b0;
        step(5);
        sw[1] = 1'b1;
        step(30);
        sw[1] = 1'b0;
        step(5);
        sw[1] = 1'b1;
        step(80);

        // ch2 strobe, period 4, then switch low.
        set_per(2, 4); set_mode(2, 2'b11); sw[2] = 1'b1;
        step(130);
        sw[2] = 1'b0;
        step(10);

        // ch3 period 0 in toggle.
        set_per(3, 0); set_mode(3, 2'b01); sw[3] = 1'b1;
        step(50);

        // ch0 toggle -> strobe mid-count.
        wait_cnt(0, 1, "wait_modechg");
        set_mode(0, 2'b11);
        step(1);
        check("modechg_wrap", 32'(wrap[0]), 32'd0);
        check("modechg_led", 32'(led[0]), 32'd0);
        step(20);

        // Shrink period 8 -> 2 while the count is 5.
        set_mode(0, 2'b01); set_per(0, 8);
        wait_cnt(0, 5, "wait_shrink");
        set_per(0, 2);
        wraps = 0;
        for (int i = 0; i < DIV; i++) begin
            step(1);
            wraps += int'(wrap[0]);
        end
        check("shrink_wraps", 32'(wraps), 32'd1);

        // Random switching, mode and period changes.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) sw[$urandom_range(0, CH-1)] ^= 1'b1;
            if ($urandom_range(0, 149) == 0) set_mode(int'($urandom_range(0, CH-1)), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 99) == 0) set_per(int'($urandom_range(0, CH-1)), int'($urandom_range(0, 6)));
            if (c == 1500) async_reset();
            step(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
